// File: rtl/arbiter_2to1_rr_pkg.sv
// Shared types and client encodings for the 2-client round-robin arbiter.
package arbiter_pkg;

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} arb_state_t;

  // Matches the sel encoding consumed by decoder_2to1
  localparam logic CLIENT0 = 1'b0;
  localparam logic CLIENT1 = 1'b1;

endpackage

// File: rtl/arbiter_2to1_rr_if.sv
// Request/grant bundle between the two clients and the round-robin arbiter.
interface arbiter_2to1_rr_if #(
  parameter int CNT_W = 2
);
  logic             req0;
  logic             req1;
  logic             done;
  logic             en;
  logic             sel;
  logic [CNT_W-1:0] hold_cnt;
  logic             switch_p;

  modport master (
    output req0, req1, done,
    input  en, sel, hold_cnt, switch_p
  );

  modport slave (
    input  req0, req1, done,
    output en, sel, hold_cnt, switch_p
  );
endinterface

// File: rtl/arbiter_2to1_rr_hold_counter.sv
// Saturating hold counter: counts granted cycles, stops at MAX_HOLD-1.
module hold_counter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = $clog2(MAX_HOLD)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             at_max
);

  assign at_max = (cnt == CNT_W'(MAX_HOLD - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && !at_max) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/arbiter_2to1_rr.sv
// Two-client round-robin arbiter producing registered en/sel for decoder_2to1,
// with bounded hold time under contention and direct owner-to-owner handoff.
module arbiter_2to1_rr
  import arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = $clog2(MAX_HOLD)
) (
  input  logic             clk,
  input  logic             rst,
  arbiter_2to1_rr_if.slave bus
);

  arb_state_t       state, state_n;
  logic             last, last_n;
  logic             en_q, sel_q, sw_q;
  logic             switch_n;
  logic             cnt_clr;
  logic             at_max;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last  <= CLIENT1;
      en_q  <= 1'b0;
      sel_q <= 1'b0;
      sw_q  <= 1'b0;
    end else begin
      state <= state_n;
      last  <= last_n;
      en_q  <= (state_n != IDLE);
      sel_q <= (state_n == GRANT1);
      sw_q  <= switch_n;
    end
  end

  always_comb begin
    state_n  = state;
    switch_n = 1'b0;
    last_n   = last;
    case (state)
      IDLE: begin
        if (bus.req0 && bus.req1) begin
          state_n = (last == CLIENT0) ? GRANT1 : GRANT0;
        end else if (bus.req0) begin
          state_n = GRANT0;
        end else if (bus.req1) begin
          state_n = GRANT1;
        end
      end
      GRANT0: begin
        if (bus.req1 && (bus.done || !bus.req0 || at_max)) begin
          state_n  = GRANT1;
          switch_n = 1'b1;
        end else if (bus.done || !bus.req0) begin
          state_n = IDLE;
        end
      end
      GRANT1: begin
        if (bus.req0 && (bus.done || !bus.req1 || at_max)) begin
          state_n  = GRANT0;
          switch_n = 1'b1;
        end else if (bus.done || !bus.req1) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (state_n == GRANT0) begin
      last_n = CLIENT0;
    end else if (state_n == GRANT1) begin
      last_n = CLIENT1;
    end
  end

  // Counter restarts on any state change (grant entry) and while idle
  assign cnt_clr = (state_n != state) || (state_n == IDLE);

  hold_counter #(
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (CNT_W)
  ) u_hold (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .en     (!cnt_clr),
    .cnt    (cnt),
    .at_max (at_max)
  );

  assign bus.en       = en_q;
  assign bus.sel      = sel_q;
  assign bus.hold_cnt = cnt;
  assign bus.switch_p = sw_q;

endmodule

// File: doc/arbiter_2to1_rr.md
# arbiter_2to1_rr

Two-client round-robin arbiter that produces the registered `en`/`sel` pair consumed by the 2-to-1 decoder. The decoder's `y0`/`y1` outputs then serve as one-hot grants back to clients 0 and 1. The arbiter owns all sequencing: request sampling, fair tie-breaking, bounded hold time and release. The decoder stays purely combinational.

## Interface
- `MAX_HOLD`, default 4: maximum consecutive granted cycles while the other client is waiting. Legal range is ≥ 2.
- `CNT_W`, default `$clog2(MAX_HOLD)`: width of the hold counter. Derived; do not override.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0`  in  1  client 0 requests the shared resource; level-held until served.
- `req1`  in  1  client 1 requests the shared resource; level-held until served.
- `done`  in  1  current owner finishes this cycle; ignored in IDLE.
- `en`  out  1  registered decoder enable; 1 when any grant is active.
- `sel`  out  1  registered decoder select; 0 means client 0 owns, 1 means client 1 owns.
- `hold_cnt`  out  CNT_W  cycles the current owner has held minus 1; 0 on the first granted cycle.
- `switch_p`  out  1  one-cycle pulse on the first cycle of a grant change between owners.

## Operation
- **States:** IDLE, GRANT0, GRANT1.
  - Outputs are decoded from registered state: IDLE gives en=0, sel=0. GRANT0 gives en=1, sel=0. GRANT1 gives en=1, sel=1.
- **`last` register:** holds the most recently granted client. It updates on every entry to a grant state.
- **IDLE:**
  - Only req0 → GRANT0.
  - Only req1 → GRANT1.
  - Both → grant the client ≠ `last`.
  - Neither → stay in IDLE.
- **GRANTx (owner x, other y):**
  - If req_y and (done, or !req_x, or hold_cnt == MAX_HOLD-1) → go directly to GRANTy. No idle bubble; `switch_p` = 1 on the first GRANTy cycle.
  - Else if done or !req_x → IDLE.
  - Else stay in GRANTx.
- **hold_cnt:**
  - Cleared on entry to any grant state and in IDLE.
  - Otherwise increments by 1 each cycle in a grant state, saturating at MAX_HOLD-1.
  - Saturation without a waiting client does not preempt the owner.
- **`done` with req_x still high and no req_y:** the FSM still goes to IDLE. It re-grants x on the following cycle.
- **Reset values:** state=IDLE, en=0, sel=0, hold_cnt=0, switch_p=0, `last`=1, so client 0 wins the first tie.

## Timing
- All inputs are sampled at rising edge k; outputs reflect the decision after edge k.
- Request-to-grant latency is exactly 1 cycle from IDLE.
- Owner-to-owner handoff takes 1 cycle. `en` stays high across the handoff; `sel` flips in the same cycle.
- Under continuous contention, each client holds exactly MAX_HOLD cycles, alternating.
- `rst` has priority over all inputs. Asserted mid-grant, it forces en=0 after the next edge, regardless of req/done.
- `done` and a dropped req in the same cycle are treated as a single release.
- Outputs are glitch-free because they come straight from flops; there is no combinational input-to-output path.

## Structure
- **`arbiter_pkg`:**
  - `typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} arb_state_t`.
  - Client index constants `CLIENT0 = 1'b0` and `CLIENT1 = 1'b1`. These match the `sel` encoding expected by the decoder.
- **Sub-module `hold_counter`:** CNT_W wide, with clear, enable and saturate-at-`MAX_HOLD-1` behaviour. It also provides an `at_max` flag. Instantiated once.
- **Integration:** the top-level integration instantiates `arbiter_2to1_rr` feeding `decoder_2to1`. The decoder's `y0`/`y1` are the client grants.

## Test plan
- **Reset:** assert rst for 2 cycles with req0=req1=1, then deassert.
  - During reset: en=0, sel=0, hold_cnt=0.
  - 1 cycle after release: en=1, sel=0.
- **Single requester:** req0=1 only, held 6 cycles, done pulsed on cycle 6.
  - en=1 and sel=0 from cycle 1.
  - hold_cnt counts 0,1,2,3,3,3 (saturates at 3 when MAX_HOLD=4).
  - en=0 the cycle after done.
- **Contention fairness:** MAX_HOLD=4, req0=req1=1 for 16 cycles.
  - sel pattern is 0000 1111 0000 1111 with en constantly 1.
  - switch_p pulses at cycles 5, 9 and 13.
- **Early release:** owner client 1 with req0 waiting; assert done at hold_cnt=1.
  - Next cycle: sel=0, hold_cnt=0, switch_p=1.
- **Request drop:** in GRANT0, drop req0 with req1=0.
  - Next cycle: IDLE, en=0.
  - Then raise req1: en=1, sel=1 one cycle later.
- **Mid-grant reset:** in GRANT1 at hold_cnt=2, pulse rst.
  - Next cycle: en=0, hold_cnt=0.
  - Then with req0=req1=1: client 0 is granted first.
